pipeline_trace_buffer: RTL and testbench
========================================

Name: pipeline_trace_buffer

Overview:
Synthesizable, parametrised multi-channel trace capture for the pipelined processor. It records per-cycle snapshots of selected stage signals (IF/ID/EX/MEM/WB buses) into a circular buffer, with arm and trigger control and a configurable post-trigger window. Samples are read back afterwards through a registered random-access port. It sits beside PIPELINE and taps stage outputs without affecting them.

Parameters:
DATA_W, 32, width of each channel sample
CHANNELS, 8, number of traced buses
DEPTH, 16, samples per channel; power of 2, >= 4
POST_TRIG, 8, samples captured after the trigger sample; 0..DEPTH-1
ADDR_W, $clog2(DEPTH), derived
CH_W, $clog2(CHANNELS) (min 1), derived

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
arm  in  1  start or restart capture
trig  in  1  trigger qualifier
cap_en  in  1  capture this cycle (pipeline not stalled)
ch_data  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
rd_en  in  1  readback request
rd_idx  in  ADDR_W  logical sample index; 0 = oldest
rd_ch  in  CH_W  channel select
rd_data  out  DATA_W  registered read data
rd_valid  out  1  high one cycle after rd_en
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
done  out  1  state==DONE
fill_cnt  out  ADDR_W+1  stored samples, saturates at DEPTH
trig_idx  out  ADDR_W  logical index of the trigger sample; valid when done

Behaviour:
- Reset: state=IDLE; wr_ptr=0, fill_cnt=0, post_cnt=0, trig_idx=0, rd_data=0, rd_valid=0, done=0. Storage is not cleared.
- Write: writes mem[wr_ptr] for all channels; wr_ptr increments mod DEPTH; fill_cnt increments to a maximum of DEPTH.
- IDLE: no writes. arm=1 -> ARMED next cycle, with wr_ptr=0 and fill_cnt=0.
- ARMED: cap_en=1 performs a write.
  - trig=1 with cap_en=1: the trigger sample is written. Go to DONE if POST_TRIG=0, else go to POST with post_cnt=POST_TRIG.
  - trig=1 with cap_en=0: ignored.
- POST: cap_en=1 performs a write and post_cnt decrements. The write made while post_cnt==1 moves the block to DONE. trig is ignored.
- DONE: no writes; contents are frozen.
- arm=1 in ARMED, POST or DONE: restart. Next state is ARMED, wr_ptr=0, fill_cnt=0, no write that cycle. arm has priority over trig and cap_en.
- Oldest physical slot: 0 if fill_cnt<DEPTH, else wr_ptr.
- trig_idx = fill_cnt-1-POST_TRIG, computed and registered on entry to DONE.
- Readback (any state): on rd_en, rd_data <= mem[(oldest+rd_idx) mod DEPTH][rd_ch] and rd_valid=1 the next cycle.
  - rd_idx >= fill_cnt or rd_ch >= CHANNELS: rd_data=0, rd_valid still 1.
  - Read and write to the same slot in one cycle returns the old contents (read-before-write).
  - rd_data holds its value when rd_en=0; rd_valid=0 in that case.
- Reset mid-capture: return to IDLE. fill_cnt=0, so all reads return 0.

Test Plan:
1. Reset, then cap_en=1 and toggling data for 30 cycles without arm -> state=0, fill_cnt=0; read rd_idx=0 -> rd_data=0, rd_valid=1 one cycle later.
2. Settings CHANNELS=4, DEPTH=16, POST_TRIG=8; arm; ch0=sample number k=1,2,...; trig at k=20 -> done after k=28, fill_cnt=16, trig_idx=7; rd_idx 0 ch0 -> 13; rd_idx 7 -> 20; rd_idx 15 -> 28.
3. Early trigger: arm, trig at k=3 -> done after k=11, fill_cnt=11, trig_idx=2; rd_idx 2 -> 3; rd_idx 12 -> 0.
4. cap_en alternating 1/0 in ARMED and POST; trig asserted once with cap_en=0 (ignored), later with cap_en=1 -> DONE only after 8 further captured samples; no duplicates or gaps in readback sequence.
5. Restart and reset: arm with trig simultaneously in ARMED -> next fill_cnt=0, state=ARMED, no write; rst during POST -> state=0, done=0, reads return 0.
6. Settings CHANNELS=3, CH_W=2; ch2=0xA5A5A5A5 captured -> rd_ch=2 returns 0xA5A5A5A5; rd_ch=3 returns 0 with rd_valid=1.

Source files
------------

// File: rtl/pipeline_trace_buffer.sv
// Multi-channel pipeline trace capture: circular sample buffer with arm/trigger
// control, a post-trigger window and a registered random-access readback port.
module pipeline_trace_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         trig,
    input  logic                         cap_en,
    input  logic [CHANNELS*DATA_W-1:0]   ch_data,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_idx,
    input  logic [CH_W-1:0]              rd_ch,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic [1:0]                   state,
    output logic                         done,
    output logic [ADDR_W:0]              fill_cnt,
    output logic [ADDR_W-1:0]            trig_idx
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned ROW_W = CHANNELS * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]   trig_idx_q, trig_idx_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic [ADDR_W-1:0]   oldest;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ROW_W-1:0]    rd_row;
    logic [DATA_W-1:0]   rd_word;

    logic [ROW_W-1:0]    mem_q [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arm always wins over trig and cap_en
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (arm) begin
                    state_d = S_ARMED;
                end else if (cap_en && trig) begin
                    state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (arm) begin
                    state_d = S_ARMED;
                end else if (cap_en && (post_cnt_q == ADDR_W'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (arm) state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture datapath and readback
    always_comb begin
        wr_en      = !arm && cap_en && ((state_q == S_ARMED) || (state_q == S_POST));
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        post_cnt_d = post_cnt_q;
        trig_idx_d = trig_idx_q;
        done_d     = (state_d == S_DONE);

        if (arm) begin
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fill_cnt_q != CNT_W'(DEPTH)) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
            if (state_q == S_ARMED && trig) begin
                post_cnt_d = ADDR_W'(POST_TRIG);
            end else if (state_q == S_POST) begin
                post_cnt_d = post_cnt_q - ADDR_W'(1);
            end
        end

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            trig_idx_d = ADDR_W'(fill_cnt_d - CNT_W'(1) - CNT_W'(POST_TRIG));
        end

        // Logical index 0 maps to slot 0 until the buffer wraps, then to wr_ptr
        oldest  = (fill_cnt_q == CNT_W'(DEPTH)) ? wr_ptr_q : '0;
        rd_addr = oldest + rd_idx;
        rd_row  = mem_q[rd_addr];
        rd_word = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (CH_W'(c) == rd_ch) rd_word = rd_row[c*DATA_W +: DATA_W];
        end

        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = (CNT_W'(rd_idx) >= fill_cnt_q) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            post_cnt_q <= '0;
            trig_idx_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            post_cnt_q <= post_cnt_d;
            trig_idx_q <= trig_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    // Sample storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= ch_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign done     = done_q;
    assign fill_cnt = fill_cnt_q;
    assign trig_idx = trig_idx_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Scoreboard bench for pipeline_trace_buffer: a 4-channel/POST_TRIG=8 instance
// and a 3-channel/POST_TRIG=0 instance sharing clock and reset.
module tb_pipeline_trace_buffer;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: CHANNELS=4, DEPTH=16, POST_TRIG=8
    logic          a_arm, a_trig, a_cap, a_rd_en;
    logic [127:0]  a_data;
    logic [3:0]    a_rd_idx;
    logic [1:0]    a_rd_ch;
    logic [31:0]   a_rd_data;
    logic          a_rd_valid, a_done;
    logic [1:0]    a_state;
    logic [4:0]    a_fill;
    logic [3:0]    a_trig_idx;

    // Instance B: CHANNELS=3 (CH_W=2), DEPTH=16, POST_TRIG=0
    logic          b_arm, b_trig, b_cap, b_rd_en;
    logic [95:0]   b_data;
    logic [3:0]    b_rd_idx;
    logic [1:0]    b_rd_ch;
    logic [31:0]   b_rd_data;
    logic          b_rd_valid, b_done;
    logic [1:0]    b_state;
    logic [4:0]    b_fill;
    logic [3:0]    b_trig_idx;

    pipeline_trace_buffer #(.DATA_W(32), .CHANNELS(4), .DEPTH(16), .POST_TRIG(8)) dut_a (
        .clk(clk), .rst(rst), .arm(a_arm), .trig(a_trig), .cap_en(a_cap),
        .ch_data(a_data), .rd_en(a_rd_en), .rd_idx(a_rd_idx), .rd_ch(a_rd_ch),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .state(a_state), .done(a_done),
        .fill_cnt(a_fill), .trig_idx(a_trig_idx)
    );

    pipeline_trace_buffer #(.DATA_W(32), .CHANNELS(3), .DEPTH(16), .POST_TRIG(0)) dut_b (
        .clk(clk), .rst(rst), .arm(b_arm), .trig(b_trig), .cap_en(b_cap),
        .ch_data(b_data), .rd_en(b_rd_en), .rd_idx(b_rd_idx), .rd_ch(b_rd_ch),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .state(b_state), .done(b_done),
        .fill_cnt(b_fill), .trig_idx(b_trig_idx)
    );

    int  total = 0;
    int  bad   = 0;
    sb_t a_sb[$];
    sb_t b_sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_a();
        a_arm = 1'b1;
        step();
        a_arm = 1'b0;
    endtask

    task automatic cap_a(input bit c, input bit t, input int k);
        a_cap  = c;
        a_trig = t;
        a_data = {32'(k + 3000), 32'(k + 2000), 32'(k + 1000), 32'(k)};
        step();
        a_cap  = 1'b0;
        a_trig = 1'b0;
    endtask

    task automatic rd_a(input int idx, input int ch, input logic [31:0] exp, input string tag);
        a_rd_en  = 1'b1;
        a_rd_idx = 4'(idx);
        a_rd_ch  = 2'(ch);
        a_sb.push_back('{exp, tag});
        step();
        a_rd_en  = 1'b0;
    endtask

    task automatic rd_b(input int idx, input int ch, input logic [31:0] exp, input string tag);
        b_rd_en  = 1'b1;
        b_rd_idx = 4'(idx);
        b_rd_ch  = 2'(ch);
        b_sb.push_back('{exp, tag});
        step();
        b_rd_en  = 1'b0;
    endtask

    // Scoreboard monitors: every rd_valid must match one queued request, in order
    always @(negedge clk) begin
        if (a_rd_valid) begin
            if (a_sb.size() == 0) begin
                check("a_spurious_valid", 64'(a_rd_valid), 64'd0);
            end else begin
                sb_t e;
                e = a_sb.pop_front();
                check(e.tag, 64'(a_rd_data), 64'(e.exp));
            end
        end
    end

    always @(negedge clk) begin
        if (b_rd_valid) begin
            if (b_sb.size() == 0) begin
                check("b_spurious_valid", 64'(b_rd_valid), 64'd0);
            end else begin
                sb_t e;
                e = b_sb.pop_front();
                check(e.tag, 64'(b_rd_data), 64'(e.exp));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_arm = 0; a_trig = 0; a_cap = 0; a_rd_en = 0; a_data = '0; a_rd_idx = 0; a_rd_ch = 0;
        b_arm = 0; b_trig = 0; b_cap = 0; b_rd_en = 0; b_data = '0; b_rd_idx = 0; b_rd_ch = 0;
        repeat (3) step();
        rst = 1'b0;

        check("rst_state", 64'(a_state), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_fill", 64'(a_fill), 64'd0);
        check("rst_trig_idx", 64'(a_trig_idx), 64'd0);
        check("rst_rd_valid", 64'(a_rd_valid), 64'd0);
        check("rst_rd_data", 64'(a_rd_data), 64'd0);

        // 1: captures without arm are ignored
        a_cap  = 1'b1;
        a_data = {4{32'h1234_5678}};
        for (int i = 0; i < 30; i++) begin
            a_data = ~a_data;
            step();
        end
        a_cap = 1'b0;
        check("t1_state", 64'(a_state), 64'd0);
        check("t1_fill", 64'(a_fill), 64'd0);
        rd_a(0, 0, 32'd0, "t1_rd0");

        // 2: late trigger with wrap-around
        arm_a();
        check("t2_armed", 64'(a_state), 64'd1);
        for (int k = 1; k <= 28; k++) begin
            if (k == 18) begin
                // read of the slot being overwritten returns its old sample
                a_rd_en = 1'b1; a_rd_idx = 4'd0; a_rd_ch = 2'd0;
                a_sb.push_back('{32'd2, "t2_rbw"});
            end
            cap_a(1'b1, k == 20, k);
            a_rd_en = 1'b0;
            if (k == 27) check("t2_post", 64'(a_state), 64'd2);
        end
        check("t2_state", 64'(a_state), 64'd3);
        check("t2_done", 64'(a_done), 64'd1);
        check("t2_fill", 64'(a_fill), 64'd16);
        check("t2_trig_idx", 64'(a_trig_idx), 64'd7);
        for (int k = 29; k <= 31; k++) cap_a(1'b1, 1'b0, k);
        check("t2_frozen_fill", 64'(a_fill), 64'd16);
        for (int i = 0; i < 16; i++) rd_a(i, 0, 32'(13 + i), $sformatf("t2_rd%0d", i));
        rd_a(7, 3, 32'(20 + 3000), "t2_rd7_ch3");
        step();
        check("t2_hold_data", 64'(a_rd_data), 64'(20 + 3000));
        check("t2_hold_valid", 64'(a_rd_valid), 64'd0);

        // 3: early trigger, buffer never fills
        arm_a();
        for (int k = 1; k <= 11; k++) cap_a(1'b1, k == 3, k);
        check("t3_state", 64'(a_state), 64'd3);
        check("t3_fill", 64'(a_fill), 64'd11);
        check("t3_trig_idx", 64'(a_trig_idx), 64'd2);
        rd_a(0, 0, 32'd1, "t3_rd0");
        rd_a(2, 0, 32'd3, "t3_rd2");
        rd_a(10, 1, 32'(11 + 1000), "t3_rd10");
        rd_a(12, 0, 32'd0, "t3_rd12");

        // 4: gapped capture; trig with cap_en=0 and trig in POST are ignored
        arm_a();
        begin
            int s;
            s = 0;
            for (int n = 0; n <= 22; n++) begin
                bit c, t;
                c = (n % 2 == 0);
                t = (n == 3) || (n == 6) || (n == 9) || (n == 10);
                if (c) s++;
                cap_a(c, t, c ? s : 32'hDEAD);
                if (n == 20) check("t4_post", 64'(a_state), 64'd2);
            end
        end
        check("t4_state", 64'(a_state), 64'd3);
        check("t4_fill", 64'(a_fill), 64'd12);
        check("t4_trig_idx", 64'(a_trig_idx), 64'd3);
        for (int i = 0; i < 12; i++) rd_a(i, 0, 32'(i + 1), $sformatf("t4_rd%0d", i));

        // 5: arm beats trig/cap_en; reset during POST
        arm_a();
        for (int k = 1; k <= 5; k++) cap_a(1'b1, 1'b0, k);
        a_arm = 1'b1; a_trig = 1'b1; a_cap = 1'b1;
        a_data = {4{32'd99}};
        step();
        a_arm = 1'b0; a_trig = 1'b0; a_cap = 1'b0;
        check("t5_restart_state", 64'(a_state), 64'd1);
        check("t5_restart_fill", 64'(a_fill), 64'd0);
        cap_a(1'b1, 1'b0, 1);
        cap_a(1'b1, 1'b1, 2);
        check("t5_post", 64'(a_state), 64'd2);
        check("t5_fill", 64'(a_fill), 64'd2);
        rd_a(0, 0, 32'd1, "t5_rd0");
        rd_a(1, 0, 32'd2, "t5_rd1");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_state", 64'(a_state), 64'd0);
        check("t5_rst_done", 64'(a_done), 64'd0);
        check("t5_rst_fill", 64'(a_fill), 64'd0);
        rd_a(0, 0, 32'd0, "t5_rst_rd0");

        // 6: three channels, out-of-range channel select, POST_TRIG=0
        b_arm = 1'b1;
        step();
        b_arm = 1'b0;
        b_cap = 1'b1; b_trig = 1'b1;
        b_data = {32'hA5A5_A5A5, 32'd2, 32'd1};
        step();
        b_cap = 1'b0; b_trig = 1'b0;
        check("t6_state", 64'(b_state), 64'd3);
        check("t6_fill", 64'(b_fill), 64'd1);
        check("t6_trig_idx", 64'(b_trig_idx), 64'd0);
        rd_b(0, 2, 32'hA5A5_A5A5, "t6_ch2");
        rd_b(0, 3, 32'd0, "t6_ch3");
        rd_b(0, 0, 32'd1, "t6_ch0");
        rd_b(1, 2, 32'd0, "t6_idx1");

        repeat (3) step();
        check("a_sb_empty", 64'(a_sb.size()), 64'd0);
        check("b_sb_empty", 64'(b_sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
